interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer for a 6502-style core.
// Arbitrates RES/NMI/BRK/IRQ at instruction boundaries and then walks a fixed
// seven-cycle script: two dummy reads, three stack pushes (PCH, PCL, P) and a
// two-byte vector fetch. All state advances on the falling edge of phi2, and
// rdy=0 freezes everything, including the NMI edge detector.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RES = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic        phi2,
    input  logic        resb,
    input  logic        nmib,
    input  logic        irqb,
    input  logic        i_flag,
    input  logic        sync,
    input  logic        brk_op,
    input  logic        rdy,
    output logic        seq_active,
    output logic        stack_write,
    output logic [1:0]  push_sel,
    output logic        sp_decrement,
    output logic [15:0] vec_addr,
    output logic        vec_lo_load,
    output logic        vec_hi_load,
    output logic        vpb,
    output logic        b_push,
    output logic        set_i,
    output logic        clear_d,
    output logic        seq_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_C1   = 3'd1,
        S_C2   = 3'd2,
        S_C3   = 3'd3,
        S_C4   = 3'd4,
        S_C5   = 3'd5,
        S_C6   = 3'd6,
        S_C7   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RES = 2'd0,
        SRC_NMI = 2'd1,
        SRC_BRK = 2'd2,
        SRC_IRQ = 2'd3
    } src_t;

    // All externally visible strobes, registered together so that every
    // output changes only on the phi2 falling edge that enters a state.
    typedef struct packed {
        logic        seq_active;
        logic        stack_write;
        logic [1:0]  push_sel;
        logic        sp_decrement;
        logic [15:0] vec_addr;
        logic        vec_lo_load;
        logic        vec_hi_load;
        logic        vpb;
        logic        b_push;
        logic        set_i;
        logic        clear_d;
        logic        seq_done;
    } outs_t;

    state_t state_reg;
    state_t state_next;
    src_t   src_reg;
    src_t   src_next;
    logic   res_pend_reg;
    logic   res_pend_next;
    logic   nmi_pend_reg;
    logic   nmi_pend_next;
    logic   nmib_prev_reg;
    outs_t  outs_reg;

    logic   nmi_edge;
    logic   nmi_req;
    logic   irq_pend;
    logic   brk_pend;

    // Output decode for the state being entered; idle drives vpb high and
    // everything else low, including the vector address.
    function automatic outs_t decode_outs(input state_t st, input src_t src);
        outs_t       o;
        logic [15:0] base;
        o     = '0;
        o.vpb = 1'b1;
        case (src)
            SRC_RES: base = VEC_RES;
            SRC_NMI: base = VEC_NMI;
            default: base = VEC_IRQ;
        endcase
        o.seq_active = (st != S_IDLE);
        case (st)
            S_C3: begin
                o.push_sel     = 2'b01;
                o.sp_decrement = 1'b1;
                o.stack_write  = (src != SRC_RES);
            end
            S_C4: begin
                o.push_sel     = 2'b10;
                o.sp_decrement = 1'b1;
                o.stack_write  = (src != SRC_RES);
            end
            S_C5: begin
                o.push_sel     = 2'b11;
                o.sp_decrement = 1'b1;
                o.stack_write  = (src != SRC_RES);
                o.b_push       = (src == SRC_BRK);
            end
            S_C6: begin
                o.vec_addr    = base;
                o.vpb         = 1'b0;
                o.vec_lo_load = 1'b1;
                o.set_i       = 1'b1;
                o.clear_d     = 1'b1;
            end
            S_C7: begin
                o.vec_addr    = base + 16'd1;
                o.vpb         = 1'b0;
                o.vec_hi_load = 1'b1;
                o.seq_done    = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Request qualification: the NMI edge counts in the cycle it is seen,
    // IRQ is a live level and BRK is only meaningful with the opcode fetch.
    always_comb begin
        nmi_edge = nmib_prev_reg & ~nmib;
        nmi_req  = nmi_pend_reg | nmi_edge;
        irq_pend = ~irqb & ~i_flag;
        brk_pend = sync & brk_op;
    end

    // Arbitration in IDLE (RES > NMI > BRK > IRQ) and linear sequence advance.
    // An NMI accepted during a sequence stays pending until the next boundary;
    // BRK coinciding with NMI is dropped, as on the NMOS part.
    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        res_pend_next = res_pend_reg;
        nmi_pend_next = nmi_req;
        case (state_reg)
            S_IDLE: begin
                if (res_pend_reg) begin
                    state_next    = S_C1;
                    src_next      = SRC_RES;
                    res_pend_next = 1'b0;
                end else if (sync) begin
                    if (nmi_req) begin
                        state_next    = S_C1;
                        src_next      = SRC_NMI;
                        nmi_pend_next = 1'b0;
                    end else if (brk_pend) begin
                        state_next = S_C1;
                        src_next   = SRC_BRK;
                    end else if (irq_pend) begin
                        state_next = S_C1;
                        src_next   = SRC_IRQ;
                    end
                end
            end
            S_C7:    state_next = S_IDLE;
            default: state_next = state_t'(state_reg + 3'd1);
        endcase
    end

    // Sequencer registers; reset aborts any sequence and re-arms RES, while
    // rdy low holds state, pending flags, edge history and outputs.
    always_ff @(negedge phi2 or negedge resb) begin
        if (!resb) begin
            state_reg     <= S_IDLE;
            src_reg       <= SRC_RES;
            res_pend_reg  <= 1'b1;
            nmi_pend_reg  <= 1'b0;
            nmib_prev_reg <= 1'b1;
            outs_reg      <= decode_outs(S_IDLE, SRC_RES);
        end else if (rdy) begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            res_pend_reg  <= res_pend_next;
            nmi_pend_reg  <= nmi_pend_next;
            nmib_prev_reg <= nmib;
            outs_reg      <= decode_outs(state_next, src_next);
        end
    end

    assign seq_active   = outs_reg.seq_active;
    assign stack_write  = outs_reg.stack_write;
    assign push_sel     = outs_reg.push_sel;
    assign sp_decrement = outs_reg.sp_decrement;
    assign vec_addr     = outs_reg.vec_addr;
    assign vec_lo_load  = outs_reg.vec_lo_load;
    assign vec_hi_load  = outs_reg.vec_hi_load;
    assign vpb          = outs_reg.vpb;
    assign b_push       = outs_reg.b_push;
    assign set_i        = outs_reg.set_i;
    assign clear_d      = outs_reg.clear_d;
    assign seq_done     = outs_reg.seq_done;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: directed scenarios followed by random
// stimulus, all checked cycle by cycle against a script-based reference model.
module tb_interrupt_sequencer;

    localparam int K_RES = 0;
    localparam int K_NMI = 1;
    localparam int K_BRK = 2;
    localparam int K_IRQ = 3;

    logic        phi2   = 1'b1;
    logic        resb   = 1'b1;
    logic        nmib   = 1'b1;
    logic        irqb   = 1'b1;
    logic        i_flag = 1'b1;
    logic        sync   = 1'b0;
    logic        brk_op = 1'b0;
    logic        rdy    = 1'b1;
    logic        seq_active;
    logic        stack_write;
    logic [1:0]  push_sel;
    logic        sp_decrement;
    logic [15:0] vec_addr;
    logic        vec_lo_load;
    logic        vec_hi_load;
    logic        vpb;
    logic        b_push;
    logic        set_i;
    logic        clear_d;
    logic        seq_done;

    interrupt_sequencer dut (
        .phi2         (phi2),
        .resb         (resb),
        .nmib         (nmib),
        .irqb         (irqb),
        .i_flag       (i_flag),
        .sync         (sync),
        .brk_op       (brk_op),
        .rdy          (rdy),
        .seq_active   (seq_active),
        .stack_write  (stack_write),
        .push_sel     (push_sel),
        .sp_decrement (sp_decrement),
        .vec_addr     (vec_addr),
        .vec_lo_load  (vec_lo_load),
        .vec_hi_load  (vec_hi_load),
        .vpb          (vpb),
        .b_push       (b_push),
        .set_i        (set_i),
        .clear_d      (clear_d),
        .seq_done     (seq_done)
    );

    always #5 phi2 = ~phi2;

    // One bus cycle worth of expected outputs.
    typedef struct packed {
        logic        seq_active;
        logic        stack_write;
        logic [1:0]  push_sel;
        logic        sp_dec;
        logic [15:0] vec_addr;
        logic        lo;
        logic        hi;
        logic        vpb;
        logic        b_push;
        logic        set_i;
        logic        clear_d;
        logic        done;
    } bus_t;

    bus_t dut_bus;
    assign dut_bus = {seq_active, stack_write, push_sel, sp_decrement, vec_addr,
                      vec_lo_load, vec_hi_load, vpb, b_push, set_i, clear_d, seq_done};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a sequence is a script of seven bus cycles queued at
    // acceptance and consumed one per ready cycle.
    bus_t m_cur;
    bus_t m_script[$];
    bit   m_res_pend;
    bit   m_nmi_pend;
    bit   m_nmib_last;
    int   m_kind = K_RES;

    function automatic bus_t idle_bus();
        bus_t b;
        b     = '0;
        b.vpb = 1'b1;
        return b;
    endfunction

    function automatic string kind_name(input int k);
        case (k)
            K_RES:   return "RES";
            K_NMI:   return "NMI";
            K_BRK:   return "BRK";
            default: return "IRQ";
        endcase
    endfunction

    task automatic m_reset();
        m_cur = idle_bus();
        m_script.delete();
        m_res_pend  = 1'b1;
        m_nmi_pend  = 1'b0;
        m_nmib_last = 1'b1;
    endtask

    task automatic m_load(input int kind);
        logic [15:0] base;
        bus_t        r;
        base = (kind == K_RES) ? 16'hFFFC : (kind == K_NMI) ? 16'hFFFA : 16'hFFFE;
        m_script.delete();
        for (int c = 1; c <= 7; c++) begin
            r = idle_bus();
            r.seq_active = 1'b1;
            if (c >= 3 && c <= 5) begin
                r.push_sel    = 2'(c - 2);
                r.sp_dec      = 1'b1;
                r.stack_write = (kind != K_RES);
            end
            if (c == 5) r.b_push = (kind == K_BRK);
            if (c == 6) begin
                r.vec_addr = base;
                r.vpb      = 1'b0;
                r.lo       = 1'b1;
                r.set_i    = 1'b1;
                r.clear_d  = 1'b1;
            end
            if (c == 7) begin
                r.vec_addr = base + 16'd1;
                r.vpb      = 1'b0;
                r.hi       = 1'b1;
                r.done     = 1'b1;
            end
            m_script.push_back(r);
        end
        m_kind = kind;
    endtask

    task automatic m_edge();
        int kind;
        if (!rdy) return;
        if (m_nmib_last && !nmib) m_nmi_pend = 1'b1;
        m_nmib_last = nmib;
        if (m_script.size() > 0) begin
            m_cur = m_script.pop_front();
        end else if (m_cur.seq_active) begin
            m_cur = idle_bus();
        end else begin
            kind = -1;
            if (m_res_pend) begin
                kind = K_RES;
                m_res_pend = 1'b0;
            end else if (sync) begin
                if (m_nmi_pend) begin
                    kind = K_NMI;
                    m_nmi_pend = 1'b0;
                end else if (brk_op) begin
                    kind = K_BRK;
                end else if (!irqb && !i_flag) begin
                    kind = K_IRQ;
                end
            end
            if (kind >= 0) begin
                m_load(kind);
                m_cur = m_script.pop_front();
            end
        end
    endtask

    // One phi2 cycle: DUT and model advance on the falling edge, outputs are
    // compared 1 ns later, and inputs may then be changed by the caller.
    task automatic tick(input string tag);
        @(negedge phi2);
        if (resb) m_edge();
        else m_reset();
        #1;
        check_val(tag, 32'(dut_bus), 32'(m_cur));
        if (seq_done)
            $display("seq %s done: vector hi at %h, t=%0t", kind_name(m_kind), vec_addr, $time);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic reset_pulse(input string tag);
        resb = 1'b0;
        #2;
        m_reset();
        check_val({tag, "_async"}, 32'(dut_bus), 32'(m_cur));
        tick(tag);
        resb = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        m_reset();

        // Power-on reset and RES sequence.
        #2 resb = 1'b0;
        #1;
        check_val("reset_state", 32'(dut_bus), 32'(idle_bus()));
        tick("rst_hold");
        resb = 1'b1;
        ticks(2, "res_c1c2");
        tick("res_c3");
        check_val("res_c3_spdec", 32'(sp_decrement), 32'd1);
        check_val("res_c3_nowrite", 32'(stack_write), 32'd0);
        ticks(2, "res_c4c5");
        tick("res_c6");
        check_val("res_c6_vec", 32'(vec_addr), 32'hFFFC);
        tick("res_c7");
        check_val("res_c7_vec", 32'(vec_addr), 32'hFFFD);
        check_val("res_c7_done", 32'(seq_done), 32'd1);
        tick("res_idle");

        // IRQ taken with I clear, ignored with I set.
        irqb = 1'b0; i_flag = 1'b0; sync = 1'b1;
        tick("irq_c1");
        sync = 1'b0;
        ticks(4, "irq_c2c5");
        check_val("irq_c5_bpush", 32'(b_push), 32'd0);
        tick("irq_c6");
        check_val("irq_c6_seti", 32'(set_i), 32'd1);
        tick("irq_c7");
        check_val("irq_c7_vec", 32'(vec_addr), 32'hFFFF);
        i_flag = 1'b1;
        tick("irq_idle");
        sync = 1'b1;
        ticks(3, "irq_masked");
        check_val("irq_masked_idle", 32'(seq_active), 32'd0);
        sync = 1'b0;

        // NMI edge during IRQ C4 is deferred to the next boundary.
        i_flag = 1'b0; sync = 1'b1;
        tick("irq2_c1");
        sync = 1'b0;
        ticks(3, "irq2_c2c4");
        nmib = 1'b0;
        ticks(2, "irq2_c5c6");
        tick("irq2_c7");
        check_val("irq2_c7_vec", 32'(vec_addr), 32'hFFFF);
        irqb = 1'b1;
        tick("irq2_idle");
        sync = 1'b1;
        tick("nmi_c1");
        sync = 1'b0;
        ticks(4, "nmi_c2c5");
        tick("nmi_c6");
        check_val("nmi_c6_vec", 32'(vec_addr), 32'hFFFA);
        tick("nmi_c7");
        check_val("nmi_c7_vec", 32'(vec_addr), 32'hFFFB);
        tick("nmi_idle");
        sync = 1'b1;
        ticks(3, "nmi_low_hold");
        check_val("nmi_no_rearm", 32'(seq_active), 32'd0);
        sync = 1'b0;
        nmib = 1'b1;

        // BRK beats IRQ at the same boundary.
        irqb = 1'b0; i_flag = 1'b0; sync = 1'b1; brk_op = 1'b1;
        tick("brk_c1");
        sync = 1'b0; brk_op = 1'b0;
        ticks(4, "brk_c2c5");
        check_val("brk_c5_bpush", 32'(b_push), 32'd1);
        tick("brk_c6");
        check_val("brk_c6_vec", 32'(vec_addr), 32'hFFFE);
        irqb = 1'b1;
        ticks(2, "brk_c7_idle");

        // rdy stall of three cycles in C6 of an NMI sequence.
        tick("stall_arm");
        nmib = 1'b0;
        tick("stall_edge");
        sync = 1'b1;
        tick("stall_c1");
        sync = 1'b0;
        cnt = 1;
        for (int k = 0; k < 5; k++) begin
            tick("stall_c2c6");
            cnt++;
        end
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("stall_hold");
            cnt++;
            check_val("stall_vpb", 32'(vpb), 32'd0);
            check_val("stall_vec", 32'(vec_addr), 32'hFFFA);
        end
        rdy = 1'b1;
        for (int k = 0; k < 20 && !seq_done; k++) begin
            tick("stall_resume");
            cnt++;
        end
        check_val("stall_cycles", 32'(cnt), 32'd10);
        tick("stall_idle");
        nmib = 1'b1;
        tick("rearm");

        // Reset in the middle of an NMI sequence, with a second NMI pending.
        nmib = 1'b0; sync = 1'b1;
        tick("rnmi_c1");
        sync = 1'b0;
        nmib = 1'b1;
        tick("rnmi_c2");
        nmib = 1'b0;
        ticks(2, "rnmi_c3c4");
        reset_pulse("rnmi_rst");
        check_val("rnmi_rst_active", 32'(seq_active), 32'd0);
        check_val("rnmi_rst_vpb", 32'(vpb), 32'd1);
        check_val("rnmi_rst_vec", 32'(vec_addr), 32'd0);
        resb = 1'b0;
        nmib = 1'b1;
        #1 resb = 1'b1;
        ticks(7, "rnmi_res");
        check_val("rnmi_res_vec", 32'(vec_addr), 32'hFFFD);
        tick("rnmi_idle");
        sync = 1'b1;
        ticks(3, "rnmi_discard");
        check_val("rnmi_discarded", 32'(seq_active), 32'd0);

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            sync   = ($urandom_range(0, 3) == 0);
            brk_op = ($urandom_range(0, 2) == 0);
            irqb   = ($urandom_range(0, 2) != 0);
            i_flag = 1'($urandom_range(0, 1));
            rdy    = ($urandom_range(0, 6) != 0);
            if ($urandom_range(0, 7) == 0) nmib = ~nmib;
            if ($urandom_range(0, 299) == 0) reset_pulse("rand_rst");
            else tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
